data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the RV32I single-cycle core: services the core's load/store port (address, write data, write strobe, access type) and returns load data in the same cycle. Handles byte/half/word lanes, sign/zero extension, misaligned-store suppression with a sticky error, and a small memory-mapped status/counter window. Sits outside the core, on the core's data-memory pins, opposite the instruction memory.

## Interface
- `size`, 32: data/address width.
- `DEPTH`, 1024: RAM depth in 32-bit words; must be a power of two.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Addr_in` input size: byte address from the core.
- `Data_wr` input size: store data from the core, right-aligned.
- `Mem_write` input 1: store strobe; one store per asserted cycle.
- `Mem_type_sel` input 3: access type, RV32I funct3 encoding.
- `Data_rd` output size: load data to the core, combinational.
- `Misalign` output 1: sticky misaligned-store flag.
- `Err_addr` output size: address of the first misaligned store since the last clear.

## Operation
- Type encoding: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. 011/110/111 are illegal: stores are ignored, loads return 0.
- MMIO window, decoded before RAM:
  - 0xFFFF_FFF0: cycle counter, read-only.
  - 0xFFFF_FFF4: store counter, read-only.
  - 0xFFFF_FFF8: status, bit0 = `Misalign`. A word store with `Data_wr[0]`=1 clears `Misalign` and `Err_addr`.
  - Any other MMIO access is ignored; loads return 0.
- RAM word index = `Addr_in[$clog2(DEPTH)+1:2]`; higher address bits are ignored, so addresses alias modulo 4*DEPTH.
- Stores:
  - Byte: lane `Addr_in[1:0]`.
  - Half: lanes {1,0} or {3,2} per `Addr_in[1]`.
  - Word: all lanes.
  - Untouched lanes keep their contents.
- Misaligned store (half with `Addr_in[0]`=1, word with `Addr_in[1:0]`≠0):
  - RAM is not written.
  - `Misalign` is set.
  - `Err_addr` captures `Addr_in` only if `Misalign` was 0 (first error wins).
- Loads: `Data_rd` is the selected lane(s), shifted to bit 0 and sign- or zero-extended per type. Low address bits below the access size are ignored, so a misaligned load reads the aligned-down lane. No load strobe exists, so `Data_rd` always reflects the current address and type. Loads never set `Misalign`.
- Cycle counter: +1 every clock after reset release; wraps 0xFFFF_FFFF→0.
- Store counter: +1 per accepted RAM store only (aligned, legal type, non-MMIO); wraps.

## Timing
- Load latency 0: `Data_rd` is combinational from `Addr_in`, `Mem_type_sel` and RAM contents.
- Store latency 1: RAM is written at the rising edge where `Mem_write`=1. A load of the same address in the same cycle returns the old data; the next cycle returns the new data.
- Reset (asynchronous, mid-operation allowed):
  - `Misalign`=0, `Err_addr`=0, both counters = 0.
  - RAM contents are not reset.
  - A store coincident with reset assertion is dropped.
  - `Data_rd` stays combinational during reset; MMIO reads return 0.
- Counter read in cycle N returns the value registered before edge N.
- Clear store and new error in the same cycle cannot occur (one access per cycle).

## Configuration
- `DMEM_PERF_CNT_EN` defined: cycle and store counters are present as described.
- `DMEM_PERF_CNT_EN` not defined: both counters are removed. 0xFFFF_FFF0 and 0xFFFF_FFF4 read 0 and ignore writes. Status register and misalign logic are unchanged.

## Structure
- Shared package `dmem_pkg`: type-select encodings (`MT_B`, `MT_H`, `MT_W`, `MT_BU`, `MT_HU`) and MMIO address constants (`MMIO_CYC`, `MMIO_STC`, `MMIO_STAT`).
- Sub-module `dmem_lane_align` (combinational), shared by store and load paths:
  - Store path: byte-enable mask, lane-shifted write data, misalign detect.
  - Load path: lane extract plus sign/zero extension.

## Test plan
- SW 0x8765_4321 @0x10, then LB/LBU/LH/LHU/LW @0x10..0x13 → LB@0x13 = 0xFFFF_FF87; LBU@0x13 = 0x87; LH@0x12 = 0xFFFF_8765; LHU@0x10 = 0x4321; LW = 0x8765_4321.
- SB 0xAA @0x21 over word 0 → LW @0x20 = 0x0000_AA00; SH 0xBEEF @0x22 → LW = 0xBEEF_AA00.
- SW @0x31, then SH @0x45 → RAM unchanged, `Misalign`=1, `Err_addr`=0x31; SW 1 @0xFFFF_FFF8 → `Misalign`=0, `Err_addr`=0.
- With macro: 5 legal stores + 1 misaligned + 1 MMIO store → LW @0xFFFF_FFF4 = 5; cycle counter reads increase by exactly the cycle gap.
- Store and load @0x40 in the same cycle → old value; next cycle → new value.
- Assert reset mid-store with counters nonzero → counters and flag read 0 immediately; earlier RAM data is retained; the coincident store is absent.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the RV32I data-memory responder: access-type
// encodings (RV32I funct3) and the memory-mapped register addresses.
package dmem_pkg;

  // Access types, RV32I funct3 encoding; 011/110/111 are illegal
  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;

  // MMIO window occupies 0xFFFF_FFF0..0xFFFF_FFFF and is decoded before RAM
  localparam logic [31:0] MMIO_CYC  = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_STC  = 32'hFFFF_FFF4;
  localparam logic [31:0] MMIO_STAT = 32'hFFFF_FFF8;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering shared by the store and load paths of data_mem_responder.
// Store side: byte enables, lane-replicated write data, misalign detect.
// Load side: lane extract with sign/zero extension; illegal types read 0.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mem_type,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_lane,
  output logic        misaligned,
  output logic [31:0] rd_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store path: replicate data across lanes so the byte enables alone pick the target
  always_comb begin
    byte_en    = 4'b0000;
    wr_lane    = 32'h0;
    misaligned = 1'b0;
    case (mem_type)
      MT_B, MT_BU: begin
        byte_en = 4'b0001 << addr_lo;
        wr_lane = {4{wr_data[7:0]}};
      end
      MT_H, MT_HU: begin
        wr_lane = {2{wr_data[15:0]}};
        if (addr_lo[0]) misaligned = 1'b1;
        else            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      MT_W: begin
        wr_lane = wr_data;
        if (addr_lo != 2'b00) misaligned = 1'b1;
        else                  byte_en    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load path: pick the addressed lane(s); sub-size address bits are ignored
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (mem_type)
      MT_B:    rd_data = {{24{byte_sel[7]}}, byte_sel};
      MT_BU:   rd_data = {24'h0, byte_sel};
      MT_H:    rd_data = {{16{half_sel[15]}}, half_sel};
      MT_HU:   rd_data = {16'h0, half_sel};
      MT_W:    rd_data = rd_word;
      default: rd_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I single-cycle core. Combinational
// loads, byte-enabled registered stores, sticky misaligned-store flag and a
// small MMIO window. Define DMEM_PERF_CNT_EN to include the cycle and store
// counters; without it those two registers read 0 and ignore writes.
// Only size = 32 is supported.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int size  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] Addr_in,
  input  logic [size-1:0] Data_wr,
  input  logic            Mem_write,
  input  logic [2:0]      Mem_type_sel,
  output logic [size-1:0] Data_rd,
  output logic            Misalign,
  output logic [size-1:0] Err_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [size-1:0] mem [DEPTH];
  logic [AW-1:0]   word_idx;
  logic            is_mmio;
  logic [size-1:0] mmio_word;
  logic [size-1:0] rd_word;
  logic [3:0]      byte_en;
  logic [size-1:0] wr_lane;
  logic            misaligned;
  logic            ram_store;
  logic            bad_store;
  logic            stat_clear;
  logic [size-1:0] cyc_cnt;
  logic [size-1:0] st_cnt;

  // Higher address bits fall out of the index, so RAM aliases modulo 4*DEPTH
  assign word_idx = Addr_in[AW+1:2];
  assign is_mmio  = (Addr_in[size-1:4] == MMIO_STAT[size-1:4]);

  dmem_lane_align u_lane (
    .addr_lo    (Addr_in[1:0]),
    .mem_type   (Mem_type_sel),
    .wr_data    (Data_wr),
    .rd_word    (rd_word),
    .byte_en    (byte_en),
    .wr_lane    (wr_lane),
    .misaligned (misaligned),
    .rd_data    (Data_rd)
  );

  // Illegal types and misaligned accesses produce no byte enables
  assign ram_store  = Mem_write && !is_mmio && (byte_en != 4'b0000);
  assign bad_store  = Mem_write && !is_mmio && misaligned;
  assign stat_clear = Mem_write && (Addr_in == MMIO_STAT) && (Mem_type_sel == MT_W) && Data_wr[0];

  // MMIO read word selected by Addr_in[3:2]; it then goes through the normal lane extract
  always_comb begin
    mmio_word = '0;
    if (Addr_in[3:2] == MMIO_CYC[3:2])       mmio_word = cyc_cnt;
    else if (Addr_in[3:2] == MMIO_STC[3:2])  mmio_word = st_cnt;
    else if (Addr_in[3:2] == MMIO_STAT[3:2]) mmio_word = {{(size-1){1'b0}}, Misalign};
  end

  assign rd_word = is_mmio ? mmio_word : mem[word_idx];

  // RAM write; a store in a cycle where reset is held low is dropped, contents are never reset
  always_ff @(posedge clk) begin
    if (reset && ram_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= wr_lane[i*8 +: 8];
      end
    end
  end

  // Sticky misalign flag; the first faulting address since the last clear is kept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Misalign <= 1'b0;
      Err_addr <= '0;
    end else if (stat_clear) begin
      Misalign <= 1'b0;
      Err_addr <= '0;
    end else if (bad_store) begin
      Misalign <= 1'b1;
      if (!Misalign) Err_addr <= Addr_in;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  // Free-running cycle counter and accepted-RAM-store counter, both wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      st_cnt  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (ram_store) st_cnt <= st_cnt + 1'b1;
    end
  end
`else
  assign cyc_cnt = '0;
  assign st_cnt  = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a driver issues one access per
// cycle and queues the expected response from a byte-level reference model;
// a monitor on the falling edge pops and compares.
`timescale 1ns/1ps
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Addr_in = 32'h0;
  logic [31:0] Data_wr = 32'h0;
  logic        Mem_write = 1'b0;
  logic [2:0]  Mem_type_sel = 3'b010;
  logic [31:0] Data_rd;
  logic        Misalign;
  logic [31:0] Err_addr;

  data_mem_responder #(.size(32), .DEPTH(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .Addr_in      (Addr_in),
    .Data_wr      (Data_wr),
    .Mem_write    (Mem_write),
    .Mem_type_sel (Mem_type_sel),
    .Data_rd      (Data_rd),
    .Misalign     (Misalign),
    .Err_addr     (Err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic [31:0] err;
    logic [31:0] a;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   total = 0;
  int   bad = 0;

  // Reference model: byte-addressed RAM image (aliased mod 4096) plus registers
  bit [7:0]  ram_m [4096];
  bit        mis_m = 1'b0;
  bit [31:0] err_m = 32'h0;
  bit [31:0] cyc_m = 32'h0;
  bit [31:0] stc_m = 32'h0;

  // Edges counted since reset release
  always @(posedge clk) begin
    if (!reset) cyc_m = 32'h0;
    else        cyc_m = cyc_m + 32'h1;
  end

  function automatic bit in_mmio(input bit [31:0] a);
    return a[31:4] == 28'hFFF_FFFF;
  endfunction

  function automatic bit [31:0] mmio_val(input bit [31:0] a);
    bit [31:0] al;
    al = {a[31:2], 2'b00};
    if (al == 32'hFFFF_FFF8) return {31'h0, mis_m};
`ifdef DMEM_PERF_CNT_EN
    if (al == 32'hFFFF_FFF0) return cyc_m;
    if (al == 32'hFFFF_FFF4) return stc_m;
`endif
    return 32'h0;
  endfunction

  function automatic bit [7:0] get_byte(input bit [31:0] a);
    bit [31:0] w;
    if (in_mmio(a)) begin
      w = mmio_val(a);
      return w[{a[1:0], 3'b000} +: 8];
    end
    return ram_m[a[11:0]];
  endfunction

  function automatic bit [31:0] ref_load(input bit [31:0] a, input bit [2:0] t);
    bit [7:0]  b;
    bit [15:0] h;
    bit [31:0] w;
    b = get_byte(a);
    h = {get_byte({a[31:1], 1'b1}), get_byte({a[31:1], 1'b0})};
    w = {get_byte({a[31:2], 2'd3}), get_byte({a[31:2], 2'd2}),
         get_byte({a[31:2], 2'd1}), get_byte({a[31:2], 2'd0})};
    case (t)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic flag_misalign(input bit [31:0] a);
    if (!mis_m) err_m = a;
    mis_m = 1'b1;
  endtask

  task automatic ref_store(input bit [31:0] a, input bit [31:0] d, input bit [2:0] t);
    int k;
    k = int'(a[11:0]);
    if (in_mmio(a)) begin
      if (t == 3'b010 && a == 32'hFFFF_FFF8 && d[0]) begin
        mis_m = 1'b0;
        err_m = 32'h0;
      end
      return;
    end
    case (t)
      3'b000, 3'b100: begin
        ram_m[k] = d[7:0];
        stc_m = stc_m + 1;
      end
      3'b001, 3'b101: begin
        if (a[0]) flag_misalign(a);
        else begin
          ram_m[k] = d[7:0];
          ram_m[k+1] = d[15:8];
          stc_m = stc_m + 1;
        end
      end
      3'b010: begin
        if (a[1:0] != 2'b00) flag_misalign(a);
        else begin
          for (int i = 0; i < 4; i++) ram_m[k+i] = d[8*i +: 8];
          stc_m = stc_m + 1;
        end
      end
      default: ;
    endcase
  endtask

  // One access per cycle; the expectation is taken before the store is applied
  task automatic do_cycle(input bit rst, input bit we, input bit [31:0] a, input bit [31:0] d,
                          input bit [2:0] t, input string tag, input bit use_c, input bit [31:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    Mem_write = we;
    Addr_in = a;
    Data_wr = d;
    Mem_type_sel = t;
    if (!rst) begin
      mis_m = 1'b0;
      err_m = 32'h0;
      stc_m = 32'h0;
      cyc_m = 32'h0;
    end
    e.rd  = use_c ? c : ref_load(a, t);
    e.mis = mis_m;
    e.err = err_m;
    e.a   = a;
    e.tag = tag;
    sb_q.push_back(e);
    if (rst && we) ref_store(a, d, t);
  endtask

  task automatic st(input bit [31:0] a, input bit [31:0] d, input bit [2:0] t, input string tag);
    do_cycle(1'b1, 1'b1, a, d, t, tag, 1'b0, 32'h0);
  endtask

  task automatic ld(input bit [31:0] a, input bit [2:0] t, input string tag);
    do_cycle(1'b1, 1'b0, a, 32'h0, t, tag, 1'b0, 32'h0);
  endtask

  task automatic ldc(input bit [31:0] a, input bit [2:0] t, input bit [31:0] c, input string tag);
    do_cycle(1'b1, 1'b0, a, 32'h0, t, tag, 1'b1, c);
  endtask

  // Monitor: compare outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      total++;
      if (Data_rd !== m_e.rd || Misalign !== m_e.mis || Err_addr !== m_e.err) begin
        bad++;
        $display("FAIL %s a=%h Data_rd=%h want %h Misalign=%b want %b Err_addr=%h want %h",
                 m_e.tag, m_e.a, Data_rd, m_e.rd, Misalign, m_e.mis, Err_addr, m_e.err);
      end else begin
        $display("ok   %s a=%h Data_rd=%h Misalign=%b Err_addr=%h",
                 m_e.tag, m_e.a, Data_rd, Misalign, Err_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] a;
    bit [31:0] d;
    bit [2:0]  t;
    bit        we;
    bit [31:0] cyc_exp9, cyc_exp13, stc_exp;

    // Reset state
    repeat (2) @(posedge clk);
    do_cycle(1'b0, 1'b0, MMIO_STAT, 32'h0, MT_W, "reset_stat", 1'b1, 32'h0);

    // Initialise the RAM region used by the bench (0x00..0x7F)
    for (int w = 0; w < 32; w++) st(32'(w * 4), $urandom, MT_W, "init");

    // Lane extraction with sign/zero extension
    st(32'h10, 32'h8765_4321, MT_W, "sw_10");
    ldc(32'h13, MT_B,  32'hFFFF_FF87, "lb_13");
    ldc(32'h13, MT_BU, 32'h0000_0087, "lbu_13");
    ldc(32'h12, MT_H,  32'hFFFF_8765, "lh_12");
    ldc(32'h10, MT_HU, 32'h0000_4321, "lhu_10");
    ldc(32'h11, MT_W,  32'h8765_4321, "lw_11_aligned_down");
    ldc(32'h10, MT_W,  32'h8765_4321, "lw_10");
    ldc(32'h10, 3'b011, 32'h0, "illegal_type_load");

    // Partial stores keep untouched lanes
    st(32'h20, 32'h0, MT_W, "sw_20_zero");
    st(32'h21, 32'h0000_00AA, MT_B, "sb_21");
    ldc(32'h20, MT_W, 32'h0000_AA00, "lw_20_after_sb");
    st(32'h22, 32'h0000_BEEF, MT_H, "sh_22");
    ldc(32'h20, MT_W, 32'hBEEF_AA00, "lw_20_after_sh");
    st(32'h20, 32'h1234_5678, 3'b111, "illegal_type_store");
    ldc(32'h20, MT_W, 32'hBEEF_AA00, "lw_20_after_illegal");

    // Misaligned stores, first error wins, cleared through status
    st(32'h31, 32'hCAFE_F00D, MT_W, "sw_31_misaligned");
    st(32'h45, 32'h0000_1111, MT_H, "sh_45_misaligned");
    ld(32'h30, MT_W, "lw_30_unchanged");
    ld(32'h44, MT_W, "lw_44_unchanged");
    ldc(MMIO_STAT, MT_W, 32'h1, "stat_set");
    st(MMIO_STAT, 32'h1, MT_W, "stat_clear");
    ldc(MMIO_STAT, MT_W, 32'h0, "stat_cleared");
    ldc(32'hFFFF_FFFC, MT_W, 32'h0, "mmio_unmapped");

    // Same-cycle store/load returns old data, next cycle the new
    st(32'h40, 32'h1111_1111, MT_W, "sw_40_a");
    do_cycle(1'b1, 1'b1, 32'h40, 32'h2222_2222, MT_W, "sw_40_b_old", 1'b1, 32'h1111_1111);
    ldc(32'h40, MT_W, 32'h2222_2222, "lw_40_new");
    ldc(32'h1040, MT_W, 32'h2222_2222, "lw_40_alias");

    // Counters: release reset, then 5 legal + 1 misaligned + 1 MMIO store
`ifdef DMEM_PERF_CNT_EN
    stc_exp = 32'd5; cyc_exp9 = 32'd9; cyc_exp13 = 32'd13;
`else
    stc_exp = 32'd0; cyc_exp9 = 32'd0; cyc_exp13 = 32'd0;
`endif
    do_cycle(1'b0, 1'b0, 32'h50, 32'h0, MT_W, "cnt_reset", 1'b0, 32'h0);
    do_cycle(1'b1, 1'b0, MMIO_CYC, 32'h0, MT_W, "cyc_at_release", 1'b1, 32'h0);
    st(32'h50, 32'hA5A5_0001, MT_W, "cnt_st1");
    st(32'h54, 32'h0000_0077, MT_B, "cnt_st2");
    st(32'h56, 32'h0000_7788, MT_H, "cnt_st3");
    st(32'h58, 32'hA5A5_0004, MT_W, "cnt_st4");
    st(32'h5D, 32'h0000_0099, MT_BU, "cnt_st5");
    st(32'h51, 32'h0000_4444, MT_H, "cnt_misaligned");
    st(MMIO_STC, 32'h0000_0063, MT_W, "cnt_mmio_write");
    ldc(MMIO_STC, MT_W, stc_exp, "stc_read");
    ldc(MMIO_CYC, MT_W, cyc_exp9, "cyc_read_9");
    ld(32'h50, MT_W, "idle");
    ld(32'h54, MT_W, "idle");
    ld(32'h58, MT_W, "idle");
    ldc(MMIO_CYC, MT_W, cyc_exp13, "cyc_read_13");

    // Randomized traffic over a small aliased region plus the MMIO window
    for (int i = 0; i < 300; i++) begin
      t  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else begin
        a = (32'($urandom_range(0, 20'hFFFFE)) << 12) | 32'($urandom_range(0, 127));
        if ($urandom_range(0, 2) != 0) begin
          if (t == MT_W) a[1:0] = 2'b00;
          else if (t == MT_H || t == MT_HU) a[0] = 1'b0;
        end
      end
      if (i % 50 == 49) st(MMIO_STAT, 32'h1, MT_W, "rnd_stat_clear");
      else do_cycle(1'b1, we, a, d, t, we ? "rnd_store" : "rnd_load", 1'b0, 32'h0);
    end

    // Reset asserted mid-store with counters and flag nonzero
    st(32'h45, 32'h0000_5555, MT_H, "pre_rst_misaligned");
    ld(32'h10, MT_W, "pre_rst_lw_10");
    do_cycle(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, MT_W, "rst_during_store", 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, MMIO_STC, 32'h0, MT_W, "rst_stc", 1'b1, 32'h0);
    do_cycle(1'b0, 1'b0, MMIO_CYC, 32'h0, MT_W, "rst_cyc", 1'b1, 32'h0);
    do_cycle(1'b0, 1'b0, MMIO_STAT, 32'h0, MT_W, "rst_stat", 1'b1, 32'h0);
    ld(32'h10, MT_W, "post_rst_lw_10_old");
    ld(32'h20, MT_W, "post_rst_lw_20");

    // Drain and finish
    repeat (3) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
